// File: rtl/cpu_clock_controller.sv
// Programmable CPU clock generator: halt, free-run, single-step and burst modes,
// with a debounced step button, rise/fall strobes and a rising-edge counter.
module cpu_clock_controller #(
  parameter int unsigned DIV_WIDTH       = 16,
  parameter int unsigned COUNT_WIDTH     = 32,
  parameter int unsigned BURST_WIDTH     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [DIV_WIDTH-1:0]   divide,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   step_button,
  input  logic                   clear_count,
  output logic                   cpu_clk,
  output logic                   cpu_rise,
  output logic                   cpu_fall,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [BURST_WIDTH-1:0] burst_remaining
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_HALT  = 2'd0;
  localparam logic [1:0] MODE_FREE  = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Button synchronizer and debouncer; press is a one-cycle pulse on a debounced rise
  logic            sync_q1;
  logic            sync_q2;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync_q1 <= step_button;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync_q2;
        db_cnt   <= '0;
        press    <= sync_q2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  state_t                 state;
  state_t                 state_nxt;
  logic [DIV_WIDTH-1:0]   eff_div;
  logic [DIV_WIDTH-1:0]   eff_div_nxt;
  logic [DIV_WIDTH-1:0]   phase_cnt;
  logic [DIV_WIDTH-1:0]   phase_cnt_nxt;
  logic [DIV_WIDTH-1:0]   div_in;
  logic [1:0]             run_mode;
  logic [1:0]             run_mode_nxt;
  logic                   busy_nxt;
  logic                   cpu_clk_nxt;
  logic                   cpu_rise_nxt;
  logic                   cpu_fall_nxt;
  logic [BURST_WIDTH-1:0] burst_rem_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;
  logic                   phase_done;
  logic                   press_ok;
  logic                   idle_start;
  logic                   abort;
  logic                   period_cont;

  assign div_in     = (divide == '0) ? DIV_WIDTH'(1) : divide;
  assign phase_done = (phase_cnt == '0);
  assign press_ok   = press & ((mode == MODE_STEP) |
                               ((mode == MODE_BURST) & (burst_len != '0)));
  assign idle_start = (mode == MODE_FREE) | press_ok;
  assign abort      = busy & (mode != run_mode);
  // A step always ends after one period; a burst chains periods until the count is exhausted
  assign period_cont = busy ? (~abort & (run_mode == MODE_BURST) & (burst_remaining != '0))
                            : (mode == MODE_FREE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      eff_div         <= DIV_WIDTH'(1);
      phase_cnt       <= '0;
      run_mode        <= MODE_HALT;
      busy            <= 1'b0;
      cpu_clk         <= 1'b0;
      cpu_rise        <= 1'b0;
      cpu_fall        <= 1'b0;
      burst_remaining <= '0;
      cycle_count     <= '0;
    end else begin
      state           <= state_nxt;
      eff_div         <= eff_div_nxt;
      phase_cnt       <= phase_cnt_nxt;
      run_mode        <= run_mode_nxt;
      busy            <= busy_nxt;
      cpu_clk         <= cpu_clk_nxt;
      cpu_rise        <= cpu_rise_nxt;
      cpu_fall        <= cpu_fall_nxt;
      burst_remaining <= burst_rem_nxt;
      cycle_count     <= count_nxt;
    end
  end

  // Phase sequencing: mode is only consulted at period boundaries
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (idle_start) state_nxt = HIGH;
      HIGH:    if (phase_done) state_nxt = LOW;
      LOW:     if (phase_done) state_nxt = period_cont ? HIGH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_clk_nxt   = (state_nxt == HIGH);
    cpu_rise_nxt  = (state_nxt == HIGH) && (state != HIGH);
    cpu_fall_nxt  = (state == HIGH) && (state_nxt == LOW);
    eff_div_nxt   = eff_div;
    phase_cnt_nxt = phase_cnt;
    run_mode_nxt  = run_mode;
    busy_nxt      = busy;
    burst_rem_nxt = burst_remaining;

    // divide is latched once per period so in-flight phases keep their length
    if (cpu_rise_nxt) begin
      eff_div_nxt   = div_in;
      phase_cnt_nxt = div_in - DIV_WIDTH'(1);
    end else if (cpu_fall_nxt) begin
      phase_cnt_nxt = eff_div - DIV_WIDTH'(1);
    end else if (!phase_done) begin
      phase_cnt_nxt = phase_cnt - DIV_WIDTH'(1);
    end

    if ((state == IDLE) && (state_nxt == HIGH)) begin
      run_mode_nxt = mode;
      busy_nxt     = (mode != MODE_FREE);
      if (mode == MODE_BURST) burst_rem_nxt = burst_len;
    end

    if (cpu_fall_nxt && busy && (run_mode == MODE_BURST) && (burst_remaining != '0))
      burst_rem_nxt = burst_remaining - BURST_WIDTH'(1);

    if ((state == LOW) && (state_nxt == IDLE)) begin
      busy_nxt      = 1'b0;
      burst_rem_nxt = '0;
    end

    if (clear_count)   count_nxt = '0;
    else if (cpu_rise) count_nxt = cycle_count + COUNT_WIDTH'(1);
    else               count_nxt = cycle_count;
  end

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Randomized and directed bench for cpu_clock_controller against a period-level
// reference model that tracks position within each CPU clock period.
module tb_cpu_clock_controller;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned BW = 8;
  localparam int unsigned DB = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    mode;
  logic [DW-1:0] divide;
  logic [BW-1:0] burst_len;
  logic          step_button;
  logic          clear_count;
  logic          cpu_clk;
  logic          cpu_rise;
  logic          cpu_fall;
  logic          busy;
  logic [CW-1:0] cycle_count;
  logic [BW-1:0] burst_remaining;

  cpu_clock_controller #(
    .DIV_WIDTH(DW), .COUNT_WIDTH(CW), .BURST_WIDTH(BW), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .divide(divide), .burst_len(burst_len),
    .step_button(step_button), .clear_count(clear_count), .cpu_clk(cpu_clk),
    .cpu_rise(cpu_rise), .cpu_fall(cpu_fall), .busy(busy),
    .cycle_count(cycle_count), .burst_remaining(burst_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: a period is 2*h cycles, high for positions 1..h
  bit m_inper, m_busy, m_rise, m_fall, m_press, m_lvl, m_s1, m_s2;
  int m_pos, m_h, m_kind, m_rem, m_count;
  bit win[$];

  function automatic void model_reset();
    m_inper = 0; m_busy = 0; m_rise = 0; m_fall = 0; m_press = 0;
    m_lvl = 0; m_s1 = 0; m_s2 = 0;
    m_pos = 0; m_h = 1; m_kind = 0; m_rem = 0; m_count = 0;
    win.delete();
  endfunction

  function automatic bit win_flip();
    if (win.size() != DB) return 1'b0;
    foreach (win[i]) if (win[i] == m_lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step();
    int md, dv, bl;
    bit start, prs, sample;
    md = int'(mode);
    dv = (divide == '0) ? 1 : int'(divide);
    bl = int'(burst_len);
    prs = m_press;
    start = 0;
    m_count = clear_count ? 0 : (m_count + int'(m_rise)) % 256;
    m_rise = 0;
    m_fall = 0;
    if (m_inper && m_pos < 2 * m_h) begin
      m_pos++;
      if (m_pos == m_h + 1) begin
        m_fall = 1;
        if (m_busy && m_kind == 3 && m_rem > 0) m_rem--;
      end
    end else if (m_inper) begin
      m_inper = 0;
      if (m_busy) begin
        if (md == m_kind && m_kind == 3 && m_rem > 0) start = 1;
        else begin m_busy = 0; m_rem = 0; end
      end else begin
        start = (md == 1);
      end
    end else begin
      if (md == 1) start = 1;
      else if (prs && md == 2) begin start = 1; m_busy = 1; m_kind = 2; end
      else if (prs && md == 3 && bl != 0) begin start = 1; m_busy = 1; m_kind = 3; m_rem = bl; end
    end
    if (start) begin m_inper = 1; m_pos = 1; m_h = dv; m_rise = 1; end
    sample = m_s2;
    m_s2 = m_s1;
    m_s1 = step_button;
    m_press = 0;
    win.push_back(sample);
    if (win.size() > DB) void'(win.pop_front());
    if (win_flip()) begin m_lvl = ~m_lvl; m_press = m_lvl; end
  endfunction

  task automatic compare_all();
    check("cpu_clk",         64'(cpu_clk),         64'(m_inper && m_pos <= m_h));
    check("cpu_rise",        64'(cpu_rise),        64'(m_rise));
    check("cpu_fall",        64'(cpu_fall),        64'(m_fall));
    check("busy",            64'(busy),            64'(m_busy));
    check("cycle_count",     64'(cycle_count),     64'(m_count));
    check("burst_remaining", 64'(burst_remaining), 64'(m_rem));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_rise(input int max_cyc, output int n);
    n = 0;
    do begin cycle(); n++; end while (cpu_rise !== 1'b1 && n < max_cyc);
    if (cpu_rise !== 1'b1) check("rise_timeout", 64'(0), 64'(1));
  endtask

  task automatic measure_periods(input int ncyc, input int exp, input string tag);
    int last;
    int cyc;
    last = -1;
    cyc = 0;
    repeat (ncyc) begin
      cycle();
      cyc++;
      if (cpu_rise === 1'b1) begin
        if (last >= 0) check(tag, 64'(cyc - last), 64'(exp));
        last = cyc;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rises, bc, maxrem;
    logic [CW-1:0] cc0;

    rst = 1'b0; mode = 2'd0; divide = '0; burst_len = '0;
    step_button = 1'b0; clear_count = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;

    // Free-run, divide 3 then divide 0
    mode = 2'd1; divide = 8'd3;
    measure_periods(40, 6, "period_div3");
    divide = 8'd0;
    wait_rise(20, n);
    measure_periods(20, 2, "period_div0");

    // divide 2 -> 7 while high
    divide = 8'd2;
    wait_rise(20, n);
    wait_rise(20, n);
    cycle();
    divide = 8'd7;
    wait_rise(20, n);
    check("period_kept", 64'(n + 1), 64'(4));
    wait_rise(40, n);
    check("period_new", 64'(n), 64'(14));

    // Free-run -> halt while high
    cycle();
    mode = 2'd0;
    run(30);
    check("halt_idle_clk", 64'(cpu_clk), 64'(0));

    // Step mode: short bounce, then a held press
    mode = 2'd2; divide = 8'd3;
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      step_button = (i < 2);
      cycle();
      rises += int'(cpu_rise);
    end
    check("bounce_rises", 64'(rises), 64'(0));
    cc0 = cycle_count;
    rises = 0; bc = 0;
    for (int i = 0; i < 40; i++) begin
      step_button = (i < 15);
      cycle();
      rises += int'(cpu_rise);
      bc += int'(busy);
    end
    check("step_rises", 64'(rises), 64'(1));
    check("step_busy_cycles", 64'(bc), 64'(6));
    check("step_count_delta", 64'(CW'(cycle_count - cc0)), 64'(1));

    // Burst of 5 at divide 2, with a second press while busy
    mode = 2'd3; divide = 8'd2; burst_len = 8'd5;
    rises = 0; bc = 0; maxrem = 0;
    for (int i = 0; i < 60; i++) begin
      step_button = (i < 8) || (i >= 14 && i < 22);
      cycle();
      rises += int'(cpu_rise);
      bc += int'(busy);
      if (int'(burst_remaining) > maxrem) maxrem = int'(burst_remaining);
    end
    check("burst_rises", 64'(rises), 64'(5));
    check("burst_busy_cycles", 64'(bc), 64'(20));
    check("burst_rem_max", 64'(maxrem), 64'(5));
    check("burst_rem_end", 64'(burst_remaining), 64'(0));

    // clear_count coincident with cpu_rise
    mode = 2'd1; divide = 8'd1;
    for (int k = 0; k < 5; k++) begin
      wait_rise(10, n);
      clear_count = 1'b1;
      cycle();
      clear_count = 1'b0;
      check("clear_on_rise", 64'(cycle_count), 64'(0));
    end

    // Counter wrap in fastest free-run
    divide = 8'd0;
    run(600);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) divide = DW'($urandom_range(4));
      if ($urandom_range(29) == 0) burst_len = BW'($urandom_range(5));
      if ($urandom_range(5) == 0) step_button = ~step_button;
      clear_count = ($urandom_range(59) == 0);
      cycle();
    end
    clear_count = 1'b0;
    step_button = 1'b0;

    // Asynchronous reset while cpu_clk is high
    mode = 2'd1; divide = 8'd5;
    wait_rise(40, n);
    cycle();
    #2 rst = 1'b0;
    #1;
    check("rst_async_clk", 64'(cpu_clk), 64'(0));
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    mode = 2'd0;
    rst = 1'b1;
    run(8);
    check("post_rst_idle_clk", 64'(cpu_clk), 64'(0));
    mode = 2'd1;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
